core_fpu_ctrl: RTL and testbench

Sequencer between the core's EXECUTE stage and the external floating-point unit's AXI-Stream channels (A, B, OP in; R out). It accepts a one-cycle issue request carrying an op, two operands and a destination register. It completes the three input handshakes independently, waits for and accepts the result, then returns it to the writeback path with a done pulse. BUSY stalls the core state machine while an FP op is in flight.

---
 rtl/core_fpu_pkg.sv | 27 ++
 rtl/core_axis_hold.sv | 42 ++++
 rtl/core_fpu_ctrl.sv | 147 ++++++++++++++
 tb/tb_core_fpu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_fpu_pkg.sv
// Shared FP op codes, sequencer state encoding and op-class helpers.
// No logic of its own; the decode stage uses the same op codes.
// Backpressure: n/a.
package core_fpu_pkg;

  localparam logic [2:0] OP_FADD = 3'd0;
  localparam logic [2:0] OP_FSUB = 3'd1;
  localparam logic [2:0] OP_FMUL = 3'd2;
  localparam logic [2:0] OP_FDIV = 3'd3;
  localparam logic [2:0] OP_FEQ  = 3'd4;
  localparam logic [2:0] OP_FLT  = 3'd5;
  localparam logic [2:0] OP_FLE  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } fpu_state_t;

  // Compare ops return a single truth bit in RESULT[0].
  function automatic logic is_cmp_op(input logic [2:0] op);
    return (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE);
  endfunction

endpackage

// File: rtl/core_axis_hold.sv
// One AXI-Stream source slot: holds TDATA and TVALID from load until the handshake.
// Latency: TVALID rises the edge after load, falls the edge after TVALID&&TREADY.
// Backpressure: holds indefinitely while TREADY is low; flush forces TVALID low at once.
module core_axis_hold #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         flush,
  input  logic         tready,
  output logic         tvalid,
  output logic [W-1:0] tdata,
  output logic         hold
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  // Valid/data slot: flush wins, then load, then clear on handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= 1'b1;
      dat_q <= load_dat;
    end else if (vld_q && tready) begin
      vld_q <= 1'b0;
    end
  end

  // An abort withdraws the offer in the same cycle so no late transfer slips through.
  assign tvalid = vld_q && !flush;
  assign tdata  = dat_q;
  // Still outstanding after this cycle.
  assign hold   = vld_q && !tready;

endmodule

// File: rtl/core_fpu_ctrl.sv
// Sequences one FP op: issue A/B/OP streams, accept R, return result with a DONE pulse.
// Latency: 3 cycles REQ->DONE with all readys high; watchdog aborts after TIMEOUT_CYCLES.
// Backpressure: each input stream waits on its own TREADY; R_TREADY only in WAIT_R.
module core_fpu_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [2:0]  REQ_OP,
  input  logic [31:0] REQ_RS1,
  input  logic [31:0] REQ_RS2,
  input  logic [4:0]  REQ_RD,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [4:0]  RESULT_RD,
  output logic        ERR,
  output logic [31:0] A_TDATA,
  output logic        A_TVALID,
  input  logic        A_TREADY,
  output logic [31:0] B_TDATA,
  output logic        B_TVALID,
  input  logic        B_TREADY,
  output logic [7:0]  OP_TDATA,
  output logic        OP_TVALID,
  input  logic        OP_TREADY,
  input  logic [31:0] R_TDATA,
  input  logic        R_TVALID,
  output logic        R_TREADY
);

  import core_fpu_pkg::*;

  // wd_cnt holds the number of in-flight cycles before the current one,
  // so the abort fires during the TIMEOUT_CYCLES-th in-flight cycle.
  localparam int               WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(WD_LAST_I);

  fpu_state_t       state_q, state_d;
  logic [CNT_W-1:0] wd_cnt;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic [31:0]      result_q;
  logic             err_q, err_d;
  logic             load, capture;
  logic             in_flight, abort;
  logic             a_hold, b_hold, op_hold;

  assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT_R);
  assign abort     = (TIMEOUT_CYCLES != 0) && in_flight && (wd_cnt == WD_LAST);

  core_axis_hold #(.W(32)) u_hold_a (
    .CLK(CLK), .RST(RST), .load(load), .load_dat(REQ_RS1), .flush(abort),
    .tready(A_TREADY), .tvalid(A_TVALID), .tdata(A_TDATA), .hold(a_hold)
  );

  core_axis_hold #(.W(32)) u_hold_b (
    .CLK(CLK), .RST(RST), .load(load), .load_dat(REQ_RS2), .flush(abort),
    .tready(B_TREADY), .tvalid(B_TVALID), .tdata(B_TDATA), .hold(b_hold)
  );

  core_axis_hold #(.W(8)) u_hold_op (
    .CLK(CLK), .RST(RST), .load(load), .load_dat({5'b0, REQ_OP}), .flush(abort),
    .tready(OP_TREADY), .tvalid(OP_TVALID), .tdata(OP_TDATA), .hold(op_hold)
  );

  // Next-state, issue load, result capture and error pulse decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (REQ_OP == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!(a_hold || b_hold || op_hold)) begin
          state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (R_TVALID) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, error pulse and watchdog registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wd_cnt  <= in_flight ? wd_cnt + 1'b1 : '0;
    end
  end

  // Op/rd captured at issue; result formatted by op class on acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q     <= OP_FADD;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      if (load) begin
        op_q <= REQ_OP;
        rd_q <= REQ_RD;
      end
      if (capture) begin
        result_q <= is_cmp_op(op_q) ? {31'b0, R_TDATA[0]} : R_TDATA;
      end
    end
  end

  assign R_TREADY  = (state_q == ST_WAIT_R) && !abort;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign ERR       = err_q;
  assign RESULT    = result_q;
  assign RESULT_RD = rd_q;

endmodule

// File: tb/tb_core_fpu_ctrl.sv
// Bench for core_fpu_ctrl: directed table plus randomized transactions vs a timing model.
// Inputs driven and outputs sampled at the falling edge.
// Ready/valid delays are planned per transaction in cycles after the issue cycle.
module tb_core_fpu_ctrl;

  localparam int TMO = 8;

  logic        CLK, RST, REQ;
  logic [2:0]  REQ_OP;
  logic [31:0] REQ_RS1, REQ_RS2;
  logic [4:0]  REQ_RD;
  logic        BUSY, DONE, ERR;
  logic [31:0] RESULT;
  logic [4:0]  RESULT_RD;
  logic [31:0] A_TDATA, B_TDATA, R_TDATA;
  logic [7:0]  OP_TDATA;
  logic        A_TVALID, A_TREADY, B_TVALID, B_TREADY, OP_TVALID, OP_TREADY;
  logic        R_TVALID, R_TREADY;

  int checks = 0;
  int errors = 0;

  core_fpu_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_OP(REQ_OP), .REQ_RS1(REQ_RS1),
    .REQ_RS2(REQ_RS2), .REQ_RD(REQ_RD), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .RESULT_RD(RESULT_RD), .ERR(ERR),
    .A_TDATA(A_TDATA), .A_TVALID(A_TVALID), .A_TREADY(A_TREADY),
    .B_TDATA(B_TDATA), .B_TVALID(B_TVALID), .B_TREADY(B_TREADY),
    .OP_TDATA(OP_TDATA), .OP_TVALID(OP_TVALID), .OP_TREADY(OP_TREADY),
    .R_TDATA(R_TDATA), .R_TVALID(R_TVALID), .R_TREADY(R_TREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          da, db, dop, dr;
    logic [31:0] rdata;
    logic [31:0] exp_result;
    int          exp_done;
    int          exp_err;
    bit          noise;
  } vec_t;

  vec_t vecs[12];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    REQ = 1'b0; REQ_OP = 3'd0; REQ_RS1 = '0; REQ_RS2 = '0; REQ_RD = '0;
    A_TREADY = 1'b0; B_TREADY = 1'b0; OP_TREADY = 1'b0;
    R_TVALID = 1'b0; R_TDATA = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, " BUSY"}, BUSY, 1'b0);
    chk1({tag, " DONE"}, DONE, 1'b0);
    chk1({tag, " ERR"}, ERR, 1'b0);
    chk1({tag, " A_TVALID"}, A_TVALID, 1'b0);
    chk1({tag, " B_TVALID"}, B_TVALID, 1'b0);
    chk1({tag, " OP_TVALID"}, OP_TVALID, 1'b0);
    chk1({tag, " R_TREADY"}, R_TREADY, 1'b0);
  endtask

  // Reference timing: valids appear in cycle 1, channel x handshakes in cycle 1+dx,
  // R is offered from cycle 1+dr but only taken once every input stream has finished.
  // Anything that would complete in cycle TMO or later is aborted in cycle TMO.
  task automatic run_txn(input vec_t v);
    int  mx, last_hs, acc, e, last_busy, nz_c, done_c, err_c;
    bit  rsvd, ok;
    mx = v.da;
    if (v.db > mx)  mx = v.db;
    if (v.dop > mx) mx = v.dop;
    last_hs   = 1 + mx;
    acc       = (last_hs + 1 > 1 + v.dr) ? last_hs + 1 : 1 + v.dr;
    rsvd      = (v.op == 3'd7);
    ok        = !rsvd && (acc < TMO);
    e         = rsvd ? 2 : (ok ? acc + 2 : TMO + 1);
    last_busy = rsvd ? 0 : (ok ? acc + 1 : TMO);
    nz_c      = (v.noise && !rsvd) ? int'($urandom_range(1, last_busy)) : -1;
    done_c    = 0;
    err_c     = 0;
    R_TDATA   = v.rdata;
    for (int c = 0; c <= e; c++) begin
      if (c > 0) begin
        chk1("BUSY", BUSY, c <= last_busy);
        chk1("DONE", DONE, ok && (c == acc + 1));
        chk1("ERR", ERR, rsvd ? (c == 1) : (!ok && c == TMO + 1));
        chk1("A_TVALID", A_TVALID, !rsvd && c <= 1 + v.da && c < TMO);
        chk1("B_TVALID", B_TVALID, !rsvd && c <= 1 + v.db && c < TMO);
        chk1("OP_TVALID", OP_TVALID, !rsvd && c <= 1 + v.dop && c < TMO);
        chk1("R_TREADY", R_TREADY, !rsvd && c >= last_hs + 1 && c <= acc && c < TMO);
        if (!rsvd && c <= 1 + v.da && c < TMO)  chk32("A_TDATA", A_TDATA, v.rs1);
        if (!rsvd && c <= 1 + v.db && c < TMO)  chk32("B_TDATA", B_TDATA, v.rs2);
        if (!rsvd && c <= 1 + v.dop && c < TMO) chk32("OP_TDATA", {24'b0, OP_TDATA}, {29'b0, v.op});
        if (ok && c == acc + 1) begin
          chk32("RESULT", RESULT, v.exp_result);
          chk32("RESULT_RD", {27'b0, RESULT_RD}, {27'b0, v.rd});
        end
        if (DONE && done_c == 0) done_c = c;
        if (ERR && err_c == 0)   err_c = c;
      end
      if (c == 0) begin
        REQ = 1'b1; REQ_OP = v.op; REQ_RS1 = v.rs1; REQ_RS2 = v.rs2; REQ_RD = v.rd;
      end else if (c == nz_c) begin
        REQ = 1'b1; REQ_OP = 3'($urandom_range(0, 7));
        REQ_RS1 = $urandom; REQ_RS2 = $urandom; REQ_RD = 5'($urandom_range(0, 31));
      end else begin
        REQ = 1'b0;
      end
      A_TREADY  = (c >= 1 + v.da);
      B_TREADY  = (c >= 1 + v.db);
      OP_TREADY = (c >= 1 + v.dop);
      R_TVALID  = (c >= 1 + v.dr);
      @(negedge CLK);
    end
    chk32("done_cycle", 32'(done_c), 32'(v.exp_done));
    chk32("err_cycle", 32'(err_c), 32'(v.exp_err));
    idle_inputs();
  endtask

  initial begin
    vec_t rv;
    int   mx, acc;
    //        op     rs1           rs2           rd     da db dop dr  rdata         result        done err noise
    vecs[0]  = '{3'd0, 32'h3F800000, 32'h40000000, 5'd5,  0, 0, 0, 0,  32'h40400000, 32'h40400000, 3, 0, 1'b0};
    vecs[1]  = '{3'd1, 32'h00000001, 32'h00000002, 5'd7,  0, 4, 0, 0,  32'hC0000000, 32'hC0000000, 7, 0, 1'b0};
    vecs[2]  = '{3'd5, 32'h11111111, 32'h22222222, 5'd3,  0, 0, 0, 0,  32'hFFFFFFFF, 32'h00000001, 3, 0, 1'b0};
    vecs[3]  = '{3'd4, 32'h33333333, 32'h44444444, 5'd4,  0, 0, 0, 0,  32'hFFFFFFFE, 32'h00000000, 3, 0, 1'b0};
    vecs[4]  = '{3'd3, 32'h40800000, 32'h40000000, 5'd9,  2, 1, 3, 1,  32'h3F000000, 32'h3F000000, 6, 0, 1'b1};
    vecs[5]  = '{3'd6, 32'hAAAA5555, 32'h5555AAAA, 5'd31, 1, 0, 0, 0,  32'h12345679, 32'h00000001, 4, 0, 1'b0};
    vecs[6]  = '{3'd2, 32'h40000000, 32'h40000000, 5'd1,  0, 0, 0, 31, 32'h40800000, 32'h00000000, 0, 9, 1'b0};
    vecs[7]  = '{3'd0, 32'h00000002, 32'h00000003, 5'd2,  0, 0, 0, 0,  32'h00000005, 32'h00000005, 3, 0, 1'b0};
    vecs[8]  = '{3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 5'd6,  0, 0, 0, 0,  32'h00000000, 32'h00000000, 0, 1, 1'b0};
    vecs[9]  = '{3'd2, 32'h01020304, 32'h05060708, 5'd8,  0, 0, 7, 0,  32'h00000009, 32'h00000000, 0, 9, 1'b0};
    vecs[10] = '{3'd2, 32'h0A0B0C0D, 32'h0E0F1011, 5'd10, 0, 0, 0, 6,  32'h7F7F7F7F, 32'h7F7F7F7F, 8, 0, 1'b0};
    vecs[11] = '{3'd2, 32'h12121212, 32'h34343434, 5'd11, 0, 0, 0, 7,  32'h7F7F7F7F, 32'h00000000, 0, 9, 1'b0};

    idle_inputs();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk_idle_outputs("reset");
    chk32("reset RESULT", RESULT, 32'h0);
    chk32("reset RESULT_RD", {27'b0, RESULT_RD}, 32'h0);
    chk32("reset A_TDATA", A_TDATA, 32'h0);
    chk32("reset B_TDATA", B_TDATA, 32'h0);
    chk32("reset OP_TDATA", {24'b0, OP_TDATA}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Reset in the middle of ISSUE must drop the valids without waiting for an edge.
    REQ = 1'b1; REQ_OP = 3'd0; REQ_RS1 = 32'h3F800000; REQ_RS2 = 32'h3F800000; REQ_RD = 5'd12;
    @(negedge CLK);
    idle_inputs();
    chk1("pre-reset A_TVALID", A_TVALID, 1'b1);
    chk1("pre-reset BUSY", BUSY, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk_idle_outputs("async reset");
    chk32("async reset A_TDATA", A_TDATA, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_idle_outputs("after reset");
    chk32("after reset RESULT_RD", {27'b0, RESULT_RD}, 32'h0);
    run_txn(vecs[0]);

    // Randomized transactions; expected outcome from the same timing rules.
    for (int n = 0; n < 40; n++) begin
      rv.op    = 3'($urandom_range(0, 7));
      rv.rs1   = $urandom;
      rv.rs2   = $urandom;
      rv.rd    = 5'($urandom_range(0, 31));
      rv.da    = int'($urandom_range(0, 3));
      rv.db    = int'($urandom_range(0, 3));
      rv.dop   = int'($urandom_range(0, 3));
      rv.dr    = int'($urandom_range(0, 9));
      rv.rdata = $urandom;
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_result = (rv.op >= 3'd4 && rv.op <= 3'd6) ? (rv.rdata & 32'h1) : rv.rdata;
      mx = rv.da;
      if (rv.db > mx)  mx = rv.db;
      if (rv.dop > mx) mx = rv.dop;
      acc = (mx + 2 > 1 + rv.dr) ? mx + 2 : 1 + rv.dr;
      if (rv.op == 3'd7) begin
        rv.exp_done = 0; rv.exp_err = 1;
      end else if (acc < TMO) begin
        rv.exp_done = acc + 1; rv.exp_err = 0;
      end else begin
        rv.exp_done = 0; rv.exp_err = TMO + 1;
      end
      run_txn(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
